// File: rtl/txpath_pkg.sv
// Shared types and helpers for the parametrised UART transmit path.
package txpath_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4,
      ST_BRK   = 3'd5
   } state_e;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   // Counter width able to hold 0..max_val-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val);
      if (w < 1) w = 1;
      return w;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/txpath_baud.sv
// Bit-period tick generator; counter restarts from 0 whenever clear is high.
module txpath_baud
   import txpath_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 69
) (
   input  logic clk_8mhz,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // tick_q is registered one count early so it is high exactly when cnt_q is the last count.
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else begin
         if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) cnt_d = '0;
         tick_d = (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
      end
   end

   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/txpath_gen.sv
// Parametrised UART transmitter: valid/ready byte input, optional parity,
// 1 or 2 stop bits, and an on-request line break, serialised on tx_wire.
module txpath_gen
   import txpath_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 69,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned BREAK_BITS   = 12
) (
   input  logic                 clk_8mhz,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data,
   input  logic                 valid,
   output logic                 ready,
   input  logic                 send_break,
   output logic                 tx_wire,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned BIT_W = cnt_width(max3(DATA_BITS, STOP_BITS, BREAK_BITS));

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY > PARITY_EVEN ||
       STOP_BITS < 1 || STOP_BITS > 2 || BREAK_BITS < 1) begin : g_bad_params
      $error("txpath_gen: illegal parameter set");
   end

   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 brk_q, brk_d;
   logic                 tx_q, tx_d;
   logic                 done_q, done_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 tick;
   logic                 clear_c;
   logic [BIT_W-1:0]     stop_last_c;

   // A break is always followed by a single mark period regardless of STOP_BITS.
   assign stop_last_c = brk_q ? '0 : BIT_W'(STOP_BITS - 1);
   assign clear_c     = (state_d != state_q) || (state_q == ST_IDLE);

   txpath_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk_8mhz (clk_8mhz),
      .rst_n    (rst_n),
      .clear    (clear_c),
      .tick     (tick)
   );

   always_ff @(posedge clk_8mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         brk_q     <= 1'b0;
         tx_q      <= 1'b1;
         done_q    <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_q     <= par_d;
         brk_q     <= brk_d;
         tx_q      <= tx_d;
         done_q    <= done_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
      end
   end

   // Next state; a break request beats a pending byte in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (send_break)  state_d = ST_BRK;
            else if (valid)  state_d = ST_START;
         end
         ST_START: if (tick) state_d = ST_DATA;
         ST_DATA: begin
            if (tick && bit_cnt_q == BIT_W'(DATA_BITS - 1))
               state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
         end
         ST_PAR:   if (tick) state_d = ST_STOP;
         ST_STOP:  if (tick && bit_cnt_q == stop_last_c) state_d = ST_IDLE;
         ST_BRK:   if (tick && bit_cnt_q == BIT_W'(BREAK_BITS - 1)) state_d = ST_STOP;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered outputs, all derived from the upcoming state.
   always_comb begin
      shift_d   = shift_q;
      par_d     = par_q;
      brk_d     = brk_q;
      bit_cnt_d = bit_cnt_q;
      tx_d      = 1'b1;

      if (state_d != state_q) bit_cnt_d = '0;
      else if (tick)          bit_cnt_d = bit_cnt_q + BIT_W'(1);

      if (state_q == ST_IDLE && state_d == ST_START) begin
         shift_d = data;
         par_d   = (PARITY == PARITY_ODD) ? ~^data : ^data;
         brk_d   = 1'b0;
      end
      if (state_q == ST_IDLE && state_d == ST_BRK) brk_d = 1'b1;
      if (state_q == ST_DATA && tick) shift_d = shift_q >> 1;

      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_BRK:   tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         ST_PAR:   tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      done_d  = (state_d == ST_IDLE) && (state_q != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   assign tx_wire = tx_q;
   assign done    = done_q;
   assign ready   = ready_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_txpath_gen.sv
// Directed bench for txpath_gen: frame vectors across four configurations plus
// break, back-to-back and mid-frame reset sequences.
module tb_txpath_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_v;
   logic [3:0] valid_v, brk_v;
   logic [3:0] tx_v, ready_v, busy_v, done_v;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // 0: 8N1, 1: 8E1, 2: 8O1 (all 4 clocks/bit); 3: 5N2 at 69 clocks/bit
   txpath_gen #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BREAK_BITS(12)) u_8n1 (
      .clk_8mhz(clk), .rst_n(rst_n), .data(data_v), .valid(valid_v[0]), .ready(ready_v[0]),
      .send_break(brk_v[0]), .tx_wire(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
   txpath_gen #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .BREAK_BITS(12)) u_8e1 (
      .clk_8mhz(clk), .rst_n(rst_n), .data(data_v), .valid(valid_v[1]), .ready(ready_v[1]),
      .send_break(brk_v[1]), .tx_wire(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
   txpath_gen #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .BREAK_BITS(12)) u_8o1 (
      .clk_8mhz(clk), .rst_n(rst_n), .data(data_v), .valid(valid_v[2]), .ready(ready_v[2]),
      .send_break(brk_v[2]), .tx_wire(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
   txpath_gen #(.CLKS_PER_BIT(69), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .BREAK_BITS(12)) u_5n2 (
      .clk_8mhz(clk), .rst_n(rst_n), .data(data_v[4:0]), .valid(valid_v[3]), .ready(ready_v[3]),
      .send_break(brk_v[3]), .tx_wire(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [15:0] bits;   // line levels per bit period, first-sent in bit 0
      int          nbits;
      int          cpb;
      string       name;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Called #1 after the edge that entered START/BRK; walks the frame clock by clock.
   task automatic check_seq(input int sel, input logic [15:0] bits, input int nbits,
                            input int cpb, input string name);
      int total;
      total = nbits * cpb;
      for (int c = 0; c <= total; c++) begin
         if (c < total) begin
            chk({name, "_tx"},    tx_v[sel],    bits[c / cpb]);
            chk({name, "_busy"},  busy_v[sel],  1'b1);
            chk({name, "_ready"}, ready_v[sel], 1'b0);
            chk({name, "_done"},  done_v[sel],  1'b0);
            @(posedge clk); #1;
         end else begin
            chk({name, "_end_tx"},    tx_v[sel],    1'b1);
            chk({name, "_end_busy"},  busy_v[sel],  1'b0);
            chk({name, "_end_ready"}, ready_v[sel], 1'b1);
            chk({name, "_end_done"},  done_v[sel],  1'b1);
         end
      end
   endtask

   task automatic run_frame(input int sel, input logic [7:0] d, input logic [15:0] bits,
                            input int nbits, input int cpb, input string name);
      @(negedge clk);
      data_v       = d;
      valid_v[sel] = 1'b1;
      @(posedge clk); #1;
      valid_v[sel] = 1'b0;
      data_v       = ~d;
      check_seq(sel, bits, nbits, cpb, name);
   endtask

   initial begin
      rst_n   = 1'b0;
      data_v  = 8'h00;
      valid_v = 4'h0;
      brk_v   = 4'h0;

      vecs[0] = '{0, 8'h55, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 4, "8n1_55"};
      vecs[1] = '{0, 8'h00, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 4, "8n1_00"};
      vecs[2] = '{0, 8'hFF, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4, "8n1_ff"};
      vecs[3] = '{1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, "8e1_07"};
      vecs[4] = '{2, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 4, "8o1_07"};
      vecs[5] = '{1, 8'h00, {5'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 4, "8e1_00"};
      vecs[6] = '{2, 8'h00, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 4, "8o1_00"};
      vecs[7] = '{3, 8'hFF, {8'b0, 2'b11, 5'h1F, 1'b0}, 8, 69, "5n2_1f"};

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rst_tx",    tx_v[i],    1'b1);
         chk("rst_ready", ready_v[i], 1'b1);
         chk("rst_busy",  busy_v[i],  1'b0);
         chk("rst_done",  done_v[i],  1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 8; i++)
         run_frame(vecs[i].sel, vecs[i].data, vecs[i].bits, vecs[i].nbits, vecs[i].cpb, vecs[i].name);

      // Back-to-back: valid held; data changed while busy must not corrupt the first byte.
      // The second handshake lands in the done cycle, one clock after the stop bit ends.
      @(negedge clk);
      data_v     = 8'hA5;
      valid_v[0] = 1'b1;
      @(posedge clk); #1;
      data_v = 8'h3C;
      check_seq(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, "b2b_a5");
      @(posedge clk); #1;
      valid_v[0] = 1'b0;
      check_seq(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 4, "b2b_3c");

      // Break wins over a simultaneous valid; the byte goes out right after.
      @(negedge clk);
      data_v     = 8'hA5;
      valid_v[0] = 1'b1;
      brk_v[0]   = 1'b1;
      @(posedge clk); #1;
      brk_v[0] = 1'b0;
      for (int c = 0; c < 52; c++) begin
         chk("brk_tx",    tx_v[0],    (c < 48) ? 1'b0 : 1'b1);
         chk("brk_ready", ready_v[0], 1'b0);
         chk("brk_done",  done_v[0],  1'b0);
         @(posedge clk); #1;
      end
      chk("brk_end_done", done_v[0], 1'b1);
      chk("brk_end_tx",   tx_v[0],   1'b1);
      @(posedge clk); #1;
      valid_v[0] = 1'b0;
      data_v     = 8'h00;
      check_seq(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 4, "brk_then_a5");

      // Reset in the middle of data bit 3.
      @(negedge clk);
      data_v     = 8'h55;
      valid_v[0] = 1'b1;
      @(posedge clk); #1;
      valid_v[0] = 1'b0;
      repeat (17) @(posedge clk);
      #1;
      chk("midrst_bit3", tx_v[0], 1'b0);
      chk("midrst_busy_before", busy_v[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_tx",    tx_v[0],    1'b1);
      chk("midrst_busy",  busy_v[0],  1'b0);
      chk("midrst_ready", ready_v[0], 1'b1);
      chk("midrst_done",  done_v[0],  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         chk("midrst_no_done", done_v[0], 1'b0);
         chk("midrst_idle_tx", tx_v[0],   1'b1);
      end
      run_frame(0, 8'h55, {6'b0, 1'b1, 8'h55, 1'b0}, 10, 4, "post_rst_55");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
